grayscale_arbiter: RTL and testbench

- Shares one rgb_to_grayscale datapath instance between two RGB565 pixel sources, for example two camera or line-buffer streams.
- Grants the datapath to one source per burst, where a burst ends on the source's last flag. Uses round-robin between sources.
- Tracks in-flight pixels with a tag pipeline and routes each grayscale result back to the source that issued it.
- Sits between the capture front-ends and the per-stream tracking logic.

---
 rtl/grayscale_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_grayscale_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_arbiter.sv
// Round-robin, burst-granular arbiter that shares one grayscale datapath between two
// RGB565 sources and routes each result back to its issuer via a tag pipeline.
module grayscale_arbiter #(
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 640
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [4:0]  s0_red,
  input  logic [5:0]  s0_green,
  input  logic [4:0]  s0_blue,
  input  logic        s0_last,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [4:0]  s1_red,
  input  logic [5:0]  s1_green,
  input  logic [4:0]  s1_blue,
  input  logic        s1_last,
  output logic [4:0]  gs_red,
  output logic [5:0]  gs_green,
  output logic [4:0]  gs_blue,
  output logic        gs_valid_in,
  input  logic        gs_valid_out,
  input  logic [11:0] gs_grayscale,
  output logic        m0_valid,
  output logic [11:0] m0_gray,
  output logic        m0_last,
  output logic        m1_valid,
  output logic [11:0] m1_gray,
  output logic        m1_last,
  output logic        tag_err
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               xfer;
  logic               sel;
  logic               sel_last;

  logic [LATENCY-1:0] tag_v_q, tag_src_q, tag_last_q;
  logic               tail_v, tail_src, tail_last, hit;

  logic               m0_valid_q, m0_last_q, m1_valid_q, m1_last_q;
  logic [11:0]        m0_gray_q, m1_gray_q;
  logic               tag_err_q, tag_err_d;

  // Grant decode and datapath mux; everything is forced to zero while idle.
  always_comb begin
    s0_ready    = (state_q == GRANT0);
    s1_ready    = (state_q == GRANT1);
    sel         = (state_q == GRANT1);
    xfer        = (s0_ready & s0_valid) | (s1_ready & s1_valid);
    sel_last    = sel ? s1_last : s0_last;
    gs_red      = '0;
    gs_green    = '0;
    gs_blue     = '0;
    gs_valid_in = xfer;
    case (state_q)
      GRANT0: begin
        gs_red   = s0_red;
        gs_green = s0_green;
        gs_blue  = s0_blue;
      end
      GRANT1: begin
        gs_red   = s1_red;
        gs_green = s1_green;
        gs_blue  = s1_blue;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (s0_valid && s1_valid) state_d = rr_q ? GRANT1 : GRANT0;
          else if (s0_valid)        state_d = GRANT0;
          else if (s1_valid)        state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          // A burst ends on last or when the per-grant budget is exhausted.
          if (sel_last || (burst_cnt_q == CNT_LAST)) begin
            state_d     = IDLE;
            rr_d        = ~sel;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Tag pipeline: mirrors the datapath latency so the tail lines up with gs_valid_out.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tag_v_q    <= '0;
      tag_src_q  <= '0;
      tag_last_q <= '0;
    end else begin
      tag_v_q[0]    <= xfer;
      tag_src_q[0]  <= sel;
      tag_last_q[0] <= sel_last;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_src_q[i]  <= tag_src_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  always_comb begin
    tail_v    = tag_v_q[LATENCY-1];
    tail_src  = tag_src_q[LATENCY-1];
    tail_last = tag_last_q[LATENCY-1];
    hit       = gs_valid_out & tail_v;
    tag_err_d = tag_err_q | (gs_valid_out != tail_v);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m0_valid_q <= 1'b0;
      m0_gray_q  <= '0;
      m0_last_q  <= 1'b0;
      m1_valid_q <= 1'b0;
      m1_gray_q  <= '0;
      m1_last_q  <= 1'b0;
      tag_err_q  <= 1'b0;
    end else begin
      m0_valid_q <= hit & ~tail_src;
      m1_valid_q <= hit & tail_src;
      if (hit && !tail_src) begin
        m0_gray_q <= gs_grayscale;
        m0_last_q <= tail_last;
      end
      if (hit && tail_src) begin
        m1_gray_q <= gs_grayscale;
        m1_last_q <= tail_last;
      end
      tag_err_q <= tag_err_d;
    end
  end

  assign m0_valid = m0_valid_q;
  assign m0_gray  = m0_gray_q;
  assign m0_last  = m0_last_q;
  assign m1_valid = m1_valid_q;
  assign m1_gray  = m1_gray_q;
  assign m1_last  = m1_last_q;
  assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_grayscale_arbiter.sv
// Scoreboard bench for grayscale_arbiter with a behavioural fixed-latency datapath model.
module tb_grayscale_arbiter;
  localparam int LAT  = 2;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn, enable, inject;
  logic s0_valid, s0_ready, s0_last, s1_valid, s1_ready, s1_last;
  logic [4:0] s0_red, s0_blue, s1_red, s1_blue, gs_red, gs_blue;
  logic [5:0] s0_green, s1_green, gs_green;
  logic gs_valid_in, gs_valid_out;
  logic [11:0] gs_grayscale, m0_gray, m1_gray;
  logic m0_valid, m0_last, m1_valid, m1_last, tag_err;

  grayscale_arbiter #(.LATENCY(LAT), .MAX_BURST(MAXB)) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_red(s0_red), .s0_green(s0_green),
    .s0_blue(s0_blue), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_red(s1_red), .s1_green(s1_green),
    .s1_blue(s1_blue), .s1_last(s1_last),
    .gs_red(gs_red), .gs_green(gs_green), .gs_blue(gs_blue), .gs_valid_in(gs_valid_in),
    .gs_valid_out(gs_valid_out), .gs_grayscale(gs_grayscale),
    .m0_valid(m0_valid), .m0_gray(m0_gray), .m0_last(m0_last),
    .m1_valid(m1_valid), .m1_gray(m1_gray), .m1_last(m1_last),
    .tag_err(tag_err)
  );

  // Datapath model: result = {blue[0], red, green} after LAT cycles.
  logic [LAT-1:0] mv;
  logic [11:0]    md [LAT];
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mv <= '0;
      for (int i = 0; i < LAT; i++) md[i] <= '0;
    end else begin
      mv[0] <= gs_valid_in;
      md[0] <= {gs_blue[0], gs_red, gs_green};
      for (int i = 1; i < LAT; i++) begin
        mv[i] <= mv[i-1];
        md[i] <= md[i-1];
      end
    end
  end
  assign gs_valid_out = mv[LAT-1] | inject;
  assign gs_grayscale = md[LAT-1];

  logic [47:0] all_outs;
  assign all_outs = {s0_ready, s1_ready, gs_red, gs_green, gs_blue, gs_valid_in,
                     m0_valid, m0_gray, m0_last, m1_valid, m1_gray, m1_last, tag_err};

  typedef struct {
    logic [11:0] gray;
    logic        last;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t me;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int grant_log[$];
  int bubbles, max0, run0, m0_cnt, m1_cnt;
  logic pr0 = 1'b0, pr1 = 1'b0;
  bit s1_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int src, input logic [4:0] r, input logic [5:0] g,
                       input logic [4:0] b, input logic l);
    if (src == 0) begin
      s0_valid = 1'b1; s0_red = r; s0_green = g; s0_blue = b; s0_last = l;
    end else begin
      s1_valid = 1'b1; s1_red = r; s1_green = g; s1_blue = b; s1_last = l;
    end
  endtask

  task automatic idle_src(input int src);
    if (src == 0) begin s0_valid = 1'b0; s0_last = 1'b0; end
    else          begin s1_valid = 1'b0; s1_last = 1'b0; end
  endtask

  // Issue n pixels from a negedge; expectation is pushed when the transfer is committed.
  task automatic send(input int src, input int n, input logic [4:0] r0, input logic [5:0] g0,
                      input bit end_last);
    logic [4:0] r, b;
    logic [5:0] g;
    logic       l;
    int         to;
    exp_t       e;
    for (int i = 0; i < n; i++) begin
      r = r0 + 5'(i);
      g = g0 + 6'(i);
      b = r + 5'd3;
      l = end_last && (i == n - 1);
      drive(src, r, g, b, l);
      to = 0;
      while (!((src == 0) ? s0_ready : s1_ready)) begin
        @(negedge clk);
        to++;
        if (to > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout src%0d: ready never seen, required within 200 cycles", src);
          idle_src(src);
          return;
        end
      end
      e.gray = {b[0], r, g};
      e.last = l;
      e.cyc  = cyc + LAT + 1;
      if (src == 0) q0.push_back(e); else q1.push_back(e);
      @(negedge clk);
    end
    idle_src(src);
  endtask

  // Monitor: pops the scoreboard on every result and tracks grant behaviour.
  always @(negedge clk) begin
    #2;
    if (aresetn) begin
      if (m0_valid) begin
        m0_cnt++;
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL m0_unexpected: got m0_valid=1, required no result");
        end else begin
          me = q0.pop_front();
          check("m0_gray", 64'(m0_gray), 64'(me.gray));
          check("m0_last", 64'(m0_last), 64'(me.last));
          check("m0_latency_cycle", 64'(cyc), 64'(me.cyc));
        end
      end
      if (m1_valid) begin
        m1_cnt++;
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL m1_unexpected: got m1_valid=1, required no result");
        end else begin
          me = q1.pop_front();
          check("m1_gray", 64'(m1_gray), 64'(me.gray));
          check("m1_last", 64'(m1_last), 64'(me.last));
          check("m1_latency_cycle", 64'(cyc), 64'(me.cyc));
        end
      end
      if (s0_valid && s0_ready) run0++;
      else begin
        if (run0 > max0) max0 = run0;
        run0 = 0;
      end
      if (s0_ready && !pr0) grant_log.push_back(0);
      if (s1_ready && !pr1) grant_log.push_back(1);
      pr0 = s0_ready;
      pr1 = s1_ready;
      if ((s0_valid || s1_valid) && !s0_ready && !s1_ready && enable) bubbles++;
    end
  end

  task automatic clear_trackers();
    grant_log.delete();
    bubbles = 0; max0 = 0; run0 = 0; m0_cnt = 0; m1_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    clear_trackers();
  endtask

  task automatic drain(input string tag);
    repeat (LAT + 4) @(negedge clk);
    #1;
    check({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
    check({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
    check({tag, "_tag_err"}, 64'(tag_err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; enable = 1'b1; inject = 1'b0;
    s0_valid = 0; s0_red = 0; s0_green = 0; s0_blue = 0; s0_last = 0;
    s1_valid = 0; s1_red = 0; s1_green = 0; s1_blue = 0; s1_last = 0;
    clear_trackers();
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // Single-source burst
    @(negedge clk);
    send(0, 4, 5'd30, 6'd50, 1'b1);
    drain("single");
    check("single_m0_count", 64'(m0_cnt), 64'd4);
    check("single_m1_count", 64'(m1_cnt), 64'd0);

    // Contention: alternating grants with one-cycle bubbles
    do_reset();
    fork
      begin send(0, 3, 5'd1, 6'd2, 1'b1); send(0, 3, 5'd4, 6'd8, 1'b1); end
      begin send(1, 3, 5'd17, 6'd33, 1'b1); send(1, 3, 5'd20, 6'd40, 1'b1); end
    join
    drain("contention");
    check("contention_grants", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("contention_grant%0d", i),
            64'((i < grant_log.size()) ? grant_log[i] : 9), 64'(i % 2));
    check("contention_bubbles", 64'(bubbles), 64'd4);

    // Forced release after MAXB transfers
    do_reset();
    fork
      begin send(0, 10, 5'd0, 6'd0, 1'b0); send(0, 1, 5'd10, 6'd10, 1'b1); end
      begin
        repeat (2) @(negedge clk);
        send(1, 2, 5'd25, 6'd60, 1'b1);
        send(1, 2, 5'd27, 6'd62, 1'b1);
      end
    join
    drain("forced");
    check("forced_max_run", 64'(max0), 64'(MAXB));
    check("forced_grants", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("forced_grant%0d", i),
            64'((i < grant_log.size()) ? grant_log[i] : 9), 64'(i % 2));
    check("forced_m0_count", 64'(m0_cnt), 64'd11);

    // Enable dropped mid-burst
    do_reset();
    fork
      send(0, 4, 5'd5, 6'd5, 1'b1);
      begin repeat (3) @(negedge clk); enable = 1'b0; end
    join
    s1_done = 1'b0;
    fork
      begin send(1, 2, 5'd20, 6'd20, 1'b1); s1_done = 1'b1; end
    join_none
    repeat (5) begin
      @(negedge clk);
      #1 check("enable_low_s1_ready", 64'(s1_ready), 64'd0);
    end
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    #1 check("enable_high_s1_ready", 64'(s1_ready), 64'd1);
    for (int t = 0; t < 100 && !s1_done; t++) @(negedge clk);
    check("enable_s1_done", 64'(s1_done), 64'd1);
    drain("enable");
    check("enable_m0_count", 64'(m0_cnt), 64'd4);
    check("enable_m1_count", 64'(m1_cnt), 64'd2);

    // Reset with a pixel in flight
    do_reset();
    @(negedge clk);
    drive(0, 5'd7, 6'd7, 5'd7, 1'b0);
    for (int t = 0; t < 20 && !s0_ready; t++) @(negedge clk);
    check("midreset_granted", 64'(s0_ready), 64'd1);
    @(negedge clk);
    aresetn = 1'b0;
    idle_src(0);
    #1 check("midreset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    clear_trackers();
    repeat (LAT + 4) @(negedge clk);
    #1 check("midreset_no_stale_m0", 64'(m0_cnt + m1_cnt), 64'd0);
    check("midreset_tag_err", 64'(tag_err), 64'd0);

    // Spurious datapath valid
    do_reset();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #1 check("tag_err_set", 64'(tag_err), 64'd1);
    repeat (4) @(negedge clk);
    #1 check("tag_err_sticky", 64'(tag_err), 64'd1);
    check("tag_err_no_result", 64'(m0_cnt + m1_cnt), 64'd0);
    aresetn = 1'b0;
    #1 check("tag_err_cleared", 64'(tag_err), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
